// File: rtl/mult_seq_param_if.sv
// mult_seq_param_if: operand/result bundle between a requester and the sequential multiplier
interface mult_seq_param_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 2
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;
  logic [7*DIGITS-1:0]  hex;
  modport master (
    output start, signed_mode, multiplier, multiplicand,
    input  product, busy, done, hex
  );
  modport slave (
    input  start, signed_mode, multiplier, multiplicand,
    output product, busy, done, hex
  );
endinterface

// File: rtl/mult_seq_param.sv
// mult_seq_param: radix-2 shift-add multiplier, one bit per cycle, sign-magnitude signed mode, seven-segment readout
module mult_seq_param #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_param_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, product_q, product_d, acc_sum;
  logic [WIDTH-1:0]     mplier_q, mplier_d, a_mag, b_mag;
  logic                 neg_q, neg_d;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction
  // Signed operands are multiplied as magnitudes; the sign is reapplied to the final sum.
  assign a_mag   = (bus.signed_mode && bus.multiplier[WIDTH-1]) ? -bus.multiplier : bus.multiplier;
  assign b_mag   = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  // Next state: accept start outside RUN, otherwise iterate and publish on the last bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (state_q != RUN && bus.start) begin
      state_d  = RUN;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, b_mag};
      mplier_d = a_mag;
      neg_d    = bus.signed_mode & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d   = DONE;
        product_d = neg_q ? -acc_sum : acc_sum;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end
  assign bus.product = product_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  for (genvar i = 0; i < DIGITS; i++) begin : g_hex
    assign bus.hex[7*i +: 7] = seg7(product_q[4*i +: 4]);
  end
endmodule

// File: tb/tb_mult_seq_param.sv
// tb_mult_seq_param: scoreboard bench for 8-bit and 32-bit multiplier instances
module tb_mult_seq_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   nb8 = 0;
  int   nb32 = 0;
  typedef struct {
    logic [63:0] p;
    int          t;
  } exp_t;
  exp_t q8[$];
  exp_t q32[$];
  mult_seq_param_if #(.WIDTH(8),  .DIGITS(2)) if8 ();
  mult_seq_param_if #(.WIDTH(32), .DIGITS(2)) if32 ();
  mult_seq_param #(.WIDTH(8),  .DIGITS(2)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  mult_seq_param #(.WIDTH(32), .DIGITS(2)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction
  function automatic logic [13:0] hexexp(input logic [63:0] p);
    return {seg(p[7:4]), seg(p[3:0])};
  endfunction
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b, input logic sm);
    longint sa, sb, p;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (sm && a[w-1]) sa -= longint'(64'd1 << w);
    if (sm && b[w-1]) sb -= longint'(64'd1 << w);
    p = sa * sb;
    return (w == 32) ? 64'(p) : (64'(p) & ((64'd1 << (2 * w)) - 64'd1));
  endfunction
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    if8.multiplier   = a;
    if8.multiplicand = b;
    if8.signed_mode  = sm;
    if8.start        = 1'b1;
    q8.push_back('{ref_mul(8, {24'b0, a}, {24'b0, b}, sm), cyc});
  endtask
  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    if32.multiplier   = a;
    if32.multiplicand = b;
    if32.signed_mode  = sm;
    if32.start        = 1'b1;
    q32.push_back('{ref_mul(32, a, b, sm), cyc});
  endtask
  task automatic wait_done(input bit w32);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = w32 ? if32.done : if8.done;
    end
    check(w32 ? "done_seen32" : "done_seen8", 64'(seen), 64'd1);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit glitch);
    @(negedge clk);
    drive8(a, b, sm);
    @(negedge clk);
    if8.start = 1'b0;
    if (glitch) begin
      @(negedge clk);
      if8.start        = 1'b1;
      if8.multiplier   = 8'h5A;
      if8.multiplicand = 8'hC3;
      if8.signed_mode  = ~sm;
      @(negedge clk);
      if8.start = 1'b0;
    end
    wait_done(1'b0);
  endtask
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    @(negedge clk);
    drive32(a, b, sm);
    @(negedge clk);
    if32.start = 1'b0;
    wait_done(1'b1);
  endtask
  task automatic b2b8();
    bit seen;
    @(negedge clk);
    drive8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 15 && !seen; k++) begin
        @(negedge clk);
        if (if8.done) seen = 1'b1;
        else if (k == 3) begin
          if8.multiplier   = 8'($urandom);
          if8.multiplicand = 8'($urandom);
          if8.signed_mode  = ~if8.signed_mode;
        end
      end
      check("b2b_done_seen", 64'(seen), 64'd1);
      if (n < 3) drive8(8'($urandom), 8'($urandom), 1'($urandom));
      else if8.start = 1'b0;
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      nb8  = 0;
      nb32 = 0;
    end
    if (if8.busy) nb8++;
    if (if32.busy) nb32++;
    if (if8.done) begin
      if (q8.size() == 0) check("spurious_done8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check("prod8", 64'(if8.product), e.p);
        check("hex8", 64'(if8.hex), 64'(hexexp(e.p)));
        check("lat8", 64'(cyc - e.t), 64'd9);
        check("busy8", 64'(nb8), 64'd8);
      end
      nb8 = 0;
    end
    if (if32.done) begin
      if (q32.size() == 0) check("spurious_done32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        check("prod32", if32.product, e.p);
        check("hex32", 64'(if32.hex), 64'(hexexp(e.p)));
        check("lat32", 64'(cyc - e.t), 64'd33);
        check("busy32", 64'(nb32), 64'd32);
      end
      nb32 = 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1);
  end
  initial begin
    logic [31:0] a, b;
    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.multiplier = '0;  if8.multiplicand = '0;
    if32.start = 1'b0; if32.signed_mode = 1'b0; if32.multiplier = '0; if32.multiplicand = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_prod8", 64'(if8.product), 64'd0);
    check("rst_busy8", 64'(if8.busy), 64'd0);
    check("rst_done8", 64'(if8.done), 64'd0);
    check("rst_hex8", 64'(if8.hex), 64'(14'b1000000_1000000));
    check("rst_prod32", if32.product, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    op8(8'd255, 8'd255, 1'b0, 1'b0);
    check("p255sq", 64'(if8.product), 64'hFE01);
    check("h255sq", 64'(if8.hex), 64'(14'b1000000_1111001));
    op8(8'hFD, 8'd5, 1'b1, 1'b0);
    check("pm3x5", 64'(if8.product), 64'hFFF1);
    check("hm3x5", 64'(if8.hex), 64'(14'b0001110_1111001));
    op8(8'h80, 8'h80, 1'b1, 1'b0);
    check("pmin2", 64'(if8.product), 64'h4000);
    op8(8'h00, 8'hA7, 1'b0, 1'b0);
    op8(8'h00, 8'hF3, 1'b1, 1'b0);
    op8(8'h7F, 8'h80, 1'b1, 1'b0);
    op8(8'hC4, 8'h3B, 1'b1, 1'b1);
    op8(8'h91, 8'hE6, 1'b0, 1'b1);
    b2b8();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h0;
      if (i % 5 == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      if (i % 5 == 2) b = 32'hFFFF_FFFF;
      op32(a, b, 1'(i));
    end
    op8(8'h3C, 8'h5D, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'hE7, 8'h9B, 1'b0);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_prod8", 64'(if8.product), 64'd0);
    check("arst_busy8", 64'(if8.busy), 64'd0);
    check("arst_done8", 64'(if8.done), 64'd0);
    check("arst_hex8", 64'(if8.hex), 64'(hexexp(64'd0)));
    check("arst_prod32", if32.product, 64'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    check("hold_prod8", 64'(if8.product), 64'd0);
    check("hold_busy8", 64'(if8.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive8(8'hB2, 8'h6E, 1'b1);
    @(negedge clk);
    if8.start = 1'b0;
    check("first_edge_busy8", 64'(if8.busy), 64'd1);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    check("queue8_empty", 64'(q8.size()), 64'd0);
    check("queue32_empty", 64'(q32.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
